keccak_perm_core: RTL and testbench

- Complete iterative Keccak-f[25*LANE_W] permutation engine built around an internal UNROLL-deep chain of combinational rounds (theta, rho, pi, chi, iota).
- Adds a round counter, an on-chip round-constant table, a start-round mode for reduced-round variants (e.g. KangarooTwelve's 12 rounds), and valid/ready handshakes on both sides.
- Sits between the sponge absorb/squeeze controller and the state register file.

---
 rtl/keccak_perm_core.sv | 135 +++++++++++++
 tb/tb_keccak_perm_core.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_perm_core.sv
// Iterative Keccak-f[25*LANE_W] permutation: UNROLL chained rounds per clock, valid/ready on both sides.
// Latency: C+1 edges from the accept edge to out_valid, C = ceil((NR-start_round)/UNROLL), 0 if start_round >= NR.
// Backpressure: result held in DONE while out_ready is low; in_ready follows out_ready there for back-to-back loads.
module keccak_perm_core #(
    parameter int LANE_W = 64,
    parameter int UNROLL = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [25*LANE_W-1:0] in_state,
    input  logic [4:0]           start_round,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [25*LANE_W-1:0] out_state,
    output logic                 busy
);
    localparam int         SW  = 25 * LANE_W;
    localparam int         L   = $clog2(LANE_W);
    localparam int         NR  = 12 + 2 * L;
    localparam logic [5:0] NR6 = 6'(NR);

    // Standard rho offsets, indexed by lane number 5*y+x.
    localparam int RHO [25] = '{ 0,  1, 62, 28, 27,
                                36, 44,  6, 55, 20,
                                 3, 10, 43, 25, 39,
                                41, 45, 15, 21,  8,
                                18,  2, 61, 56, 14};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (LANE_W != 8 && LANE_W != 16 && LANE_W != 32 && LANE_W != 64) begin : g_bad_lane
        $error("keccak_perm_core: LANE_W must be 8, 16, 32 or 64");
    end
    if (UNROLL < 1 || UNROLL > NR) begin : g_bad_unroll
        $error("keccak_perm_core: UNROLL must be in 1..NR");
    end

    // Compressed round constants: bit j lands on lane (0,0) bit 2^j-1.
    function automatic logic [7:0] rc_rom(input logic [4:0] ir);
        case (ir)
            5'd0:  rc_rom = 8'h01;  5'd1:  rc_rom = 8'h1A;  5'd2:  rc_rom = 8'h5E;
            5'd3:  rc_rom = 8'h70;  5'd4:  rc_rom = 8'h1F;  5'd5:  rc_rom = 8'h21;
            5'd6:  rc_rom = 8'h79;  5'd7:  rc_rom = 8'h55;  5'd8:  rc_rom = 8'h0E;
            5'd9:  rc_rom = 8'h0C;  5'd10: rc_rom = 8'h35;  5'd11: rc_rom = 8'h26;
            5'd12: rc_rom = 8'h3F;  5'd13: rc_rom = 8'h4F;  5'd14: rc_rom = 8'h5D;
            5'd15: rc_rom = 8'h53;  5'd16: rc_rom = 8'h52;  5'd17: rc_rom = 8'h48;
            5'd18: rc_rom = 8'h16;  5'd19: rc_rom = 8'h66;  5'd20: rc_rom = 8'h79;
            5'd21: rc_rom = 8'h58;  5'd22: rc_rom = 8'h21;  5'd23: rc_rom = 8'h74;
            default: rc_rom = 8'h00;
        endcase
    endfunction

    function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v, input int n);
        int k;
        k = n % LANE_W;
        if (k == 0) return v;
        return (v << k) | (v >> (LANE_W - k));
    endfunction

    function automatic logic [SW-1:0] keccak_round(input logic [SW-1:0] s, input logic [4:0] ir);
        logic [LANE_W-1:0] a [25];
        logic [LANE_W-1:0] b [25];
        logic [LANE_W-1:0] c [5];
        logic [LANE_W-1:0] d [5];
        logic [7:0]        rc;
        logic [SW-1:0]     r;
        for (int i = 0; i < 25; i++) a[i] = s[i*LANE_W +: LANE_W];
        for (int x = 0; x < 5; x++) c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
        for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ rotl(c[(x+1)%5], 1);
        // theta, rho and pi fused: lane (x,y) moves to (y, 2x+3y).
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                b[5*((2*x+3*y)%5) + y] = rotl(a[5*y+x] ^ d[x], RHO[5*y+x]);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                a[5*y+x] = b[5*y+x] ^ (~b[5*y+(x+1)%5] & b[5*y+(x+2)%5]);
        rc = rc_rom(ir);
        for (int j = 0; j <= L; j++) a[0][(1<<j)-1] = a[0][(1<<j)-1] ^ rc[j];
        for (int i = 0; i < 25; i++) r[i*LANE_W +: LANE_W] = a[i];
        return r;
    endfunction

    logic [1:0]    fsm_q;
    logic [SW-1:0] state_q;
    logic [4:0]    rc_q;
    logic [5:0]    rc_sum;
    logic          accept;

    // Round chain; stages whose absolute index reaches NR pass the state through.
    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        logic [SW-1:0] prev;
        logic [SW-1:0] nxt;
        logic [5:0]    idx;
        if (k == 0) begin : g_first
            assign prev = state_q;
        end else begin : g_next
            assign prev = g_round[k-1].nxt;
        end
        assign idx = {1'b0, rc_q} + 6'(k);
        assign nxt = (idx < NR6) ? keccak_round(prev, idx[4:0]) : prev;
    end

    assign rc_sum    = {1'b0, rc_q} + 6'(UNROLL);
    assign in_ready  = (fsm_q == S_IDLE) || ((fsm_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (fsm_q == S_DONE);
    assign busy      = (fsm_q == S_RUN);
    assign out_state = out_valid ? state_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            rc_q    <= '0;
        end else if (accept) begin
            state_q <= in_state;
            rc_q    <= start_round;
            fsm_q   <= ({1'b0, start_round} >= NR6) ? S_DONE : S_RUN;
        end else begin
            case (fsm_q)
                S_RUN: begin
                    state_q <= g_round[UNROLL-1].nxt;
                    rc_q    <= rc_sum[4:0];
                    if (rc_sum >= NR6) fsm_q <= S_DONE;
                end
                S_DONE: if (out_ready) fsm_q <= S_IDLE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_keccak_perm_core.sv
// Bench for keccak_perm_core: several lane-width/unroll configurations driven one at a time
// and compared against a table-free Keccak model built from the LFSR and rho-walk definitions.
module tb_keccak_perm_core;
    localparam int NI = 7;
    localparam int CFG_W [NI] = '{64, 64, 64, 64, 8, 16, 32};
    localparam int CFG_U [NI] = '{ 1,  4, 24,  5, 3,  2,  7};

    logic            clk;
    logic            rst;
    logic [1599:0]   in_bus;
    logic [4:0]      sr;
    logic [NI-1:0]   in_valid;
    logic [NI-1:0]   out_ready;
    wire  [NI-1:0]   in_ready;
    wire  [NI-1:0]   out_valid;
    wire  [NI-1:0]   busy;
    logic [1599:0]   out_bus [NI];

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] rc_bits [24];
    int         rho [5][5];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = CFG_W[g];
        logic [25*W-1:0] os;
        keccak_perm_core #(.LANE_W(W), .UNROLL(CFG_U[g])) dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .in_state(in_bus[25*W-1:0]), .start_round(sr),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .out_state(os), .busy(busy[g])
        );
        assign out_bus[g] = 1600'(os);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint unsigned lmask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic longint unsigned lane_of(input logic [1599:0] s, input int k, input int w);
        return 64'(s >> (k * w)) & lmask(w);
    endfunction

    function automatic int nr_of(input int w);
        int l = 0;
        while ((1 << l) < w) l++;
        return 12 + 2 * l;
    endfunction

    function automatic int exp_lat(input int i, input int s);
        int nr = nr_of(CFG_W[i]);
        if (s >= nr) return 1;
        return (nr - s + CFG_U[i] - 1) / CFG_U[i] + 1;
    endfunction

    // Round constants from the degree-8 LFSR; rho offsets from the (x,y) -> (y,2x+3y) walk.
    function automatic void init_tables();
        int lfsr [255];
        int r, x, y, nx;
        r = 1;
        lfsr[0] = 1;
        for (int t = 1; t < 255; t++) begin
            r = r << 1;
            if ((r & 'h100) != 0) r = r ^ 'h171;
            lfsr[t] = r & 1;
        end
        for (int ir = 0; ir < 24; ir++)
            for (int j = 0; j < 8; j++) rc_bits[ir][j] = lfsr[(j + 7*ir) % 255][0];
        rho[0][0] = 0;
        x = 1; y = 0;
        for (int t = 0; t < 24; t++) begin
            rho[x][y] = (t + 1) * (t + 2) / 2;
            nx = y;
            y  = (2*x + 3*y) % 5;
            x  = nx;
        end
    endfunction

    function automatic longint unsigned trot(input longint unsigned v, input int n, input int w);
        int k = n % w;
        if (k == 0) return v;
        return ((v << k) | (v >> (w - k))) & lmask(w);
    endfunction

    function automatic logic [1599:0] model(input logic [1599:0] st, input int w, input int s);
        longint unsigned a [5][5];
        longint unsigned b [5][5];
        longint unsigned c [5];
        longint unsigned d [5];
        longint unsigned m;
        logic [1599:0]   r;
        int l, nr;
        m = lmask(w);
        l = 0;
        while ((1 << l) < w) l++;
        nr = 12 + 2 * l;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) a[x][y] = lane_of(st, 5*y + x, w);
        for (int ir = s; ir < nr; ir++) begin
            for (int x = 0; x < 5; x++) c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
            for (int x = 0; x < 5; x++) d[x] = c[(x+4)%5] ^ trot(c[(x+1)%5], 1, w);
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++) a[x][y] = a[x][y] ^ d[x];
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++) b[y][(2*x + 3*y) % 5] = trot(a[x][y], rho[x][y], w);
            for (int x = 0; x < 5; x++)
                for (int y = 0; y < 5; y++)
                    a[x][y] = (b[x][y] ^ (~b[(x+1)%5][y] & b[(x+2)%5][y])) & m;
            for (int j = 0; j <= l; j++)
                if (rc_bits[ir][j]) a[0][0] = a[0][0] ^ (64'd1 << ((1 << j) - 1));
        end
        r = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++) r = r | (1600'(a[x][y]) << ((5*y + x) * w));
        return r;
    endfunction

    function automatic logic [1599:0] rand_state(input int w);
        logic [1599:0] s, msk;
        for (int k = 0; k < 50; k++) s[k*32 +: 32] = $urandom;
        msk = '1;
        msk = msk >> (1600 - 25 * w);
        return s & msk;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [1599:0] got, input logic [1599:0] exp, input int w);
        int bad;
        bad = 0;
        for (int k = 24; k >= 0; k--)
            if (lane_of(got, k, w) !== lane_of(exp, k, w)) bad = k;
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s lane %0d: observed %h expected %h", tag, bad,
                   lane_of(got, bad, w), lane_of(exp, bad, w));
        end
    endtask

    // Offer one state to instance i, wait (bounded) for out_valid, capture it, let the consumer take it.
    task automatic run(input int i, input logic [1599:0] st, input logic [4:0] s,
                       output int lat, output logic [1599:0] res);
        in_bus = st;
        sr = s;
        in_valid[i] = 1'b1;
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        lat = 1;
        while (!out_valid[i] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_bus[i];
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1599:0] st, st2, res, exp_st, zero;
        logic [4:0]    s;
        int            lat, nr;

        init_tables();
        zero = '0;
        rst = 1'b1;
        in_bus = '0;
        sr = '0;
        in_valid = '0;
        out_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check_val("reset_in_ready", 64'(in_ready), 64'(7'h7F));
        check_val("reset_out_valid", 64'(out_valid), 64'd0);
        check_val("reset_busy", 64'(busy), 64'd0);
        check_state("reset_out_state", out_bus[0], zero, 64);

        // Zero state, full 24 rounds, three unroll depths.
        exp_st = model(zero, 64, 0);
        for (int i = 0; i < 3; i++) begin
            run(i, zero, 5'd0, lat, res);
            check_val($sformatf("zero_lat_u%0d", CFG_U[i]), 64'(lat), 64'(exp_lat(i, 0)));
            check_state($sformatf("zero_state_u%0d", CFG_U[i]), res, exp_st, 64);
            check_val($sformatf("zero_lane00_u%0d", CFG_U[i]), res[63:0], 64'hF1258F7940E1DDE7);
            check_val($sformatf("zero_lane10_u%0d", CFG_U[i]), res[127:64], 64'h84D5CCF933C0478A);
        end

        // KangarooTwelve-style 12-round variant with UNROLL=5.
        st = rand_state(64);
        run(3, st, 5'd12, lat, res);
        check_val("k12_lat", 64'(lat), 64'd4);
        check_state("k12_state", res, model(st, 64, 12), 64);

        // Backpressure in DONE, then back-to-back load on the release edge.
        st = rand_state(64);
        exp_st = model(st, 64, 20);
        out_ready[0] = 1'b0;
        in_bus = st;
        sr = 5'd20;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        lat = 1;
        while (!out_valid[0] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("bp_lat", 64'(lat), 64'd5);
        for (int c = 0; c < 10; c++) begin
            check_state("bp_hold_state", out_bus[0], exp_st, 64);
            check_val("bp_hold_in_ready", 64'(in_ready[0]), 64'd0);
            check_val("bp_hold_out_valid", 64'(out_valid[0]), 64'd1);
            @(posedge clk); #1;
        end
        st2 = rand_state(64);
        in_bus = st2;
        sr = 5'd22;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        #1;
        check_val("b2b_in_ready", 64'(in_ready[0]), 64'd1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check_val("b2b_out_valid_drop", 64'(out_valid[0]), 64'd0);
        check_val("b2b_busy", 64'(busy[0]), 64'd1);
        lat = 1;
        while (!out_valid[0] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("b2b_lat", 64'(lat), 64'd3);
        check_state("b2b_state", out_bus[0], model(st2, 64, 22), 64);
        @(posedge clk); #1;

        // start_round past the last round: state passes straight through.
        st = rand_state(64);
        run(0, st, 5'd30, lat, res);
        check_val("skip_lat", 64'(lat), 64'd1);
        check_state("skip_state", res, st, 64);

        // Random vectors on the narrow lane widths, mostly in-range start rounds.
        for (int i = 4; i < NI; i++) begin
            nr = nr_of(CFG_W[i]);
            for (int v = 0; v < 1000; v++) begin
                st = rand_state(CFG_W[i]);
                if ($urandom_range(0, 9) == 0) s = 5'($urandom_range(nr, 31));
                else s = 5'($urandom_range(0, nr - 1));
                run(i, st, s, lat, res);
                check_val($sformatf("rand_lat_w%0d", CFG_W[i]), 64'(lat), 64'(exp_lat(i, int'(s))));
                check_state($sformatf("rand_state_w%0d", CFG_W[i]), res, model(st, CFG_W[i], int'(s)), CFG_W[i]);
            end
        end

        // Reset while instance 0 is at round 10.
        st = rand_state(64);
        in_bus = st;
        sr = 5'd0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_val("pre_rst_busy", 64'(busy[0]), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rst_out_valid", 64'(out_valid[0]), 64'd0);
        check_val("rst_busy", 64'(busy[0]), 64'd0);
        check_val("rst_in_ready", 64'(in_ready[0]), 64'd1);
        check_state("rst_out_state", out_bus[0], zero, 64);
        repeat (20) @(posedge clk);
        #1;
        check_val("rst_no_pulse", 64'(out_valid[0]), 64'd0);
        st = rand_state(64);
        run(0, st, 5'd0, lat, res);
        check_val("post_rst_lat", 64'(lat), 64'd25);
        check_state("post_rst_state", res, model(st, 64, 0), 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
